// File: rtl/sca_rdo_sched.sv
// sca_rdo_sched: readout request scheduler in front of the SCA block readout controller.
// Matched-trigger events (one or two SCA blocks each) are queued in a circular buffer and
// presented to the readout one block at a time using a present / ACK / DONE handshake.
// An event is popped only after its last block is digitized, or when a WAIT state times out.
//
// Parameters:
//   AW   log2 of queue depth (DEPTH = 2**AW events)
//   TMO  max cycles allowed in a WAIT state before timeout (12-bit timer)
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   ENA                       allow new events to start (never aborts one in progress)
//   REQ_VLD, REQ_*            one-cycle request strobe and its event fields
//   ACK, DONE                 readout accepted / finished the presented block
//   CLR_ERR                   synchronous clear of OVFL, TMO_ERR and DROP_CNT
//   GTRGEMPTY                 0 while a block is presented on RADR/L1ABIN/LCT_PHASE/SCND_*
//   RADR, L1ABIN, LCT_PHASE   presented block address and event tags
//   SCND_BLK, SCND_SHARED     presented block is the second one / the shared second one
//   FULL, COUNT               queue occupancy (COUNT includes the event in progress)
//   OVFL, DROP_CNT, TMO_ERR   sticky overflow, saturating drop count, sticky timeout
//   STATE_MON                 FSM state encoding
module sca_rdo_sched #(
  parameter int unsigned AW  = 3,
  parameter int unsigned TMO = 4095
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENA,
  input  logic          REQ_VLD,
  input  logic [3:0]    REQ_BLK1,
  input  logic [3:0]    REQ_BLK2,
  input  logic          REQ_TWO,
  input  logic          REQ_SHARED,
  input  logic [7:0]    REQ_L1ABIN,
  input  logic          REQ_LCTPH,
  input  logic          ACK,
  input  logic          DONE,
  input  logic          CLR_ERR,
  output logic          GTRGEMPTY,
  output logic [3:0]    RADR,
  output logic [7:0]    L1ABIN,
  output logic          LCT_PHASE,
  output logic          SCND_BLK,
  output logic          SCND_SHARED,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          OVFL,
  output logic          TMO_ERR,
  output logic [7:0]    DROP_CNT,
  output logic [2:0]    STATE_MON
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] FullCnt = {1'b1, {AW{1'b0}}};
  localparam logic [11:0] TmoCnt  = 12'(TMO);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPres1 = 3'd1,
    StWait1 = 3'd2,
    StPres2 = 3'd3,
    StWait2 = 3'd4
  } state_e;

  typedef struct packed {
    logic       lctph;
    logic [7:0] l1abin;
    logic       shared;
    logic       two;
    logic [3:0] blk2;
    logic [3:0] blk1;
  } entry_t;

  // Queue storage and bookkeeping
  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          new_entry;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            full_q;
  logic            wr_en, drop, pop;

  // FSM and registered outputs
  state_e          state_q, state_d;
  logic            gtrg_empty_q, gtrg_empty_d;
  logic [3:0]      radr_q, radr_d;
  logic [7:0]      l1abin_q, l1abin_d;
  logic            lct_phase_q, lct_phase_d;
  logic            scnd_blk_q, scnd_blk_d;
  logic            scnd_shared_q, scnd_shared_d;
  logic [11:0]     timer_q, timer_d;
  logic            timeout;
  logic            ovfl_q, ovfl_d;
  logic            tmo_err_q, tmo_err_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  assign new_entry = '{lctph:  REQ_LCTPH,
                       l1abin: REQ_L1ABIN,
                       shared: REQ_SHARED,
                       two:    REQ_TWO,
                       blk2:   REQ_BLK2,
                       blk1:   REQ_BLK1};

  assign head = mem[rd_ptr_q];

  // FULL comes from the registered occupancy, so a pop in the same cycle does not free a slot.
  assign wr_en = REQ_VLD & ~full_q;
  assign drop  = REQ_VLD &  full_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= new_entry;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FullCnt);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    gtrg_empty_d  = gtrg_empty_q;
    radr_d        = radr_q;
    l1abin_d      = l1abin_q;
    lct_phase_d   = lct_phase_q;
    scnd_blk_d    = scnd_blk_q;
    scnd_shared_d = scnd_shared_q;
    timer_d       = timer_q;
    pop           = 1'b0;
    timeout       = 1'b0;

    case (state_q)
      StIdle: begin
        if (ENA && count_q != '0) begin
          radr_d        = head.blk1;
          l1abin_d      = head.l1abin;
          lct_phase_d   = head.lctph;
          scnd_blk_d    = 1'b0;
          scnd_shared_d = 1'b0;
          gtrg_empty_d  = 1'b0;
          state_d       = StPres1;
        end
      end
      StPres1, StPres2: begin
        // Presenting holds indefinitely; only ACK moves on.
        if (ACK) begin
          gtrg_empty_d = 1'b1;
          timer_d      = '0;
          state_d      = (state_q == StPres1) ? StWait1 : StWait2;
        end
      end
      StWait1, StWait2: begin
        if (DONE) begin
          if (state_q == StWait1 && head.two) begin
            radr_d        = head.blk2;
            scnd_blk_d    = 1'b1;
            scnd_shared_d = head.shared;
            gtrg_empty_d  = 1'b0;
            state_d       = StPres2;
          end else begin
            pop     = 1'b1;
            state_d = StIdle;
          end
        end else if (timer_q == TmoCnt) begin
          // Stuck readout: drop the whole event so the queue keeps moving.
          timeout      = 1'b1;
          pop          = 1'b1;
          gtrg_empty_d = 1'b1;
          state_d      = StIdle;
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      default: begin
        gtrg_empty_d = 1'b1;
        state_d      = StIdle;
      end
    endcase
  end

  // Sticky error flags; a new event in the same cycle as CLR_ERR wins.
  always_comb begin
    ovfl_d     = ovfl_q;
    tmo_err_d  = tmo_err_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovfl_d = 1'b1;
      if (CLR_ERR) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (CLR_ERR) begin
      ovfl_d     = 1'b0;
      drop_cnt_d = 8'd0;
    end
    if (timeout) begin
      tmo_err_d = 1'b1;
    end else if (CLR_ERR) begin
      tmo_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      gtrg_empty_q  <= 1'b1;
      radr_q        <= '0;
      l1abin_q      <= '0;
      lct_phase_q   <= 1'b0;
      scnd_blk_q    <= 1'b0;
      scnd_shared_q <= 1'b0;
      timer_q       <= '0;
      ovfl_q        <= 1'b0;
      tmo_err_q     <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      gtrg_empty_q  <= gtrg_empty_d;
      radr_q        <= radr_d;
      l1abin_q      <= l1abin_d;
      lct_phase_q   <= lct_phase_d;
      scnd_blk_q    <= scnd_blk_d;
      scnd_shared_q <= scnd_shared_d;
      timer_q       <= timer_d;
      ovfl_q        <= ovfl_d;
      tmo_err_q     <= tmo_err_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign GTRGEMPTY   = gtrg_empty_q;
  assign RADR        = radr_q;
  assign L1ABIN      = l1abin_q;
  assign LCT_PHASE   = lct_phase_q;
  assign SCND_BLK    = scnd_blk_q;
  assign SCND_SHARED = scnd_shared_q;
  assign FULL        = full_q;
  assign COUNT       = count_q;
  assign OVFL        = ovfl_q;
  assign TMO_ERR     = tmo_err_q;
  assign DROP_CNT    = drop_cnt_q;
  assign STATE_MON   = state_q;

endmodule

// File: tb/tb_sca_rdo_sched.sv
// Bench for sca_rdo_sched: directed scenarios with literal expectations, then random traffic.
// A queue-based event model predicts every output each cycle; a compare process checks it.
module tb_sca_rdo_sched;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int TMO   = 4095;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ENA, REQ_VLD, REQ_TWO, REQ_SHARED, REQ_LCTPH, ACK, DONE, CLR_ERR;
  logic [3:0] REQ_BLK1, REQ_BLK2;
  logic [7:0] REQ_L1ABIN;
  logic       GTRGEMPTY, LCT_PHASE, SCND_BLK, SCND_SHARED, FULL, OVFL, TMO_ERR;
  logic [3:0] RADR;
  logic [7:0] L1ABIN, DROP_CNT;
  logic [AW:0] COUNT;
  logic [2:0] STATE_MON;

  sca_rdo_sched #(.AW(AW), .TMO(TMO)) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .REQ_VLD(REQ_VLD), .REQ_BLK1(REQ_BLK1),
    .REQ_BLK2(REQ_BLK2), .REQ_TWO(REQ_TWO), .REQ_SHARED(REQ_SHARED),
    .REQ_L1ABIN(REQ_L1ABIN), .REQ_LCTPH(REQ_LCTPH), .ACK(ACK), .DONE(DONE),
    .CLR_ERR(CLR_ERR), .GTRGEMPTY(GTRGEMPTY), .RADR(RADR), .L1ABIN(L1ABIN),
    .LCT_PHASE(LCT_PHASE), .SCND_BLK(SCND_BLK), .SCND_SHARED(SCND_SHARED), .FULL(FULL),
    .COUNT(COUNT), .OVFL(OVFL), .TMO_ERR(TMO_ERR), .DROP_CNT(DROP_CNT),
    .STATE_MON(STATE_MON)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0] b1;
    logic [3:0] b2;
    logic       two;
    logic       sh;
    logic [7:0] l1a;
    logic       ph;
  } ev_t;

  ev_t  mq[$];       // pending events, head = in progress
  int   m_blk;       // 0: no event active, else which block (1 or 2) is being handled
  bit   m_shown;     // current block is offered and awaits ACK
  int   m_wait;      // cycles spent waiting for DONE
  int   m_radr, m_l1a, m_drop;
  bit   m_ph, m_scnd, m_shr, m_ovfl, m_tmo;

  task automatic model_reset();
    mq.delete();
    m_blk = 0; m_shown = 0; m_wait = 0;
    m_radr = 0; m_l1a = 0; m_ph = 0; m_scnd = 0; m_shr = 0;
    m_ovfl = 0; m_tmo = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int  size0;
    bit  full0, pop, tmo_hit, drop;
    ev_t ev;
    size0   = mq.size();
    full0   = (size0 == DEPTH);
    drop    = REQ_VLD && full0;
    pop     = 0;
    tmo_hit = 0;
    if (m_blk == 0) begin
      if (ENA && size0 > 0) begin
        m_blk = 1; m_shown = 1;
        m_radr = mq[0].b1; m_l1a = mq[0].l1a; m_ph = mq[0].ph; m_scnd = 0; m_shr = 0;
      end
    end else if (m_shown) begin
      if (ACK) begin m_shown = 0; m_wait = 0; end
    end else if (DONE) begin
      if (m_blk == 1 && mq[0].two) begin
        m_blk = 2; m_shown = 1; m_radr = mq[0].b2; m_scnd = 1; m_shr = mq[0].sh;
      end else begin
        pop = 1; m_blk = 0;
      end
    end else if (m_wait == TMO) begin
      tmo_hit = 1; pop = 1; m_blk = 0;
    end else begin
      m_wait++;
    end
    if (drop) begin
      m_ovfl = 1;
      m_drop = CLR_ERR ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (CLR_ERR) begin
      m_ovfl = 0; m_drop = 0;
    end
    if (tmo_hit) m_tmo = 1;
    else if (CLR_ERR) m_tmo = 0;
    if (pop) void'(mq.pop_front());
    if (REQ_VLD && !full0) begin
      ev = '{b1: REQ_BLK1, b2: REQ_BLK2, two: REQ_TWO, sh: REQ_SHARED,
             l1a: REQ_L1ABIN, ph: REQ_LCTPH};
      mq.push_back(ev);
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) model_reset();
    else     model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      bit exp_empty;
      exp_empty = !(m_blk != 0 && m_shown);
      chk("gtrgempty", GTRGEMPTY, exp_empty);
      chk("count", COUNT, mq.size());
      chk("full", FULL, (mq.size() == DEPTH));
      chk("ovfl", OVFL, m_ovfl);
      chk("tmo_err", TMO_ERR, m_tmo);
      chk("drop_cnt", DROP_CNT, m_drop);
      chk("state_mon", STATE_MON, (m_blk == 0) ? 0 : (2 * m_blk - (m_shown ? 1 : 0)));
      if (!exp_empty) begin
        chk("radr", RADR, m_radr);
        chk("l1abin", L1ABIN, m_l1a);
        chk("lct_phase", LCT_PHASE, m_ph);
        chk("scnd_blk", SCND_BLK, m_scnd);
        chk("scnd_shared", SCND_SHARED, m_shr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send(input logic [3:0] b1, input logic [3:0] b2, input logic two,
                      input logic sh, input logic [7:0] l1a, input logic ph);
    REQ_VLD = 1; REQ_BLK1 = b1; REQ_BLK2 = b2; REQ_TWO = two; REQ_SHARED = sh;
    REQ_L1ABIN = l1a; REQ_LCTPH = ph;
    tick();
    REQ_VLD = 0;
  endtask

  task automatic pulse_ack();
    ACK = 1; tick(); ACK = 0;
  endtask

  task automatic pulse_done();
    DONE = 1; tick(); DONE = 0;
  endtask

  task automatic wait_pres(input string tag);
    int n = 0;
    while (GTRGEMPTY && n < 200) begin
      tick();
      n++;
    end
    chk(tag, GTRGEMPTY, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    ENA = 1; REQ_VLD = 0; REQ_BLK1 = 0; REQ_BLK2 = 0; REQ_TWO = 0; REQ_SHARED = 0;
    REQ_L1ABIN = 0; REQ_LCTPH = 0; ACK = 0; DONE = 0; CLR_ERR = 0;
    RST = 1;
    repeat (3) tick();
    chk("rst_gtrgempty", GTRGEMPTY, 1);
    chk("rst_count", COUNT, 0);
    chk("rst_state", STATE_MON, 0);
    chk("rst_radr", RADR, 0);
    chk("rst_drop", DROP_CNT, 0);
    RST = 0;
    tick();

    // One-block event: presented two cycles after the request
    send(4'd5, 4'd0, 0, 0, 8'h1C, 1);
    chk("t1_count", COUNT, 1);
    chk("t1_empty_n1", GTRGEMPTY, 1);
    tick();
    chk("t1_empty_n2", GTRGEMPTY, 0);
    chk("t1_radr", RADR, 5);
    chk("t1_l1abin", L1ABIN, 8'h1C);
    chk("t1_scnd", SCND_BLK, 0);
    chk("t1_state", STATE_MON, 1);
    pulse_ack();
    chk("t1_ack_empty", GTRGEMPTY, 1);
    chk("t1_ack_state", STATE_MON, 2);
    pulse_done();
    chk("t1_done_state", STATE_MON, 0);
    chk("t1_done_count", COUNT, 0);

    // Two-block event with shared second block
    send(4'd3, 4'd4, 1, 1, 8'hA5, 0);
    wait_pres("t2_pres");
    chk("t2_radr1", RADR, 3);
    chk("t2_scnd1", SCND_BLK, 0);
    pulse_ack();
    pulse_done();
    chk("t2_state2", STATE_MON, 3);
    chk("t2_radr2", RADR, 4);
    chk("t2_scnd2", SCND_BLK, 1);
    chk("t2_shared2", SCND_SHARED, 1);
    chk("t2_l1abin2", L1ABIN, 8'hA5);
    pulse_ack();
    pulse_done();
    chk("t2_count", COUNT, 0);
    chk("t2_state", STATE_MON, 0);

    // Fill the queue with no ACK, then overflow twice
    for (int i = 0; i < 8; i++) begin
      REQ_VLD = 1; REQ_BLK1 = 4'(i); REQ_TWO = 0; REQ_L1ABIN = 8'(8'h40 + i); REQ_LCTPH = 0;
      tick();
    end
    REQ_VLD = 0;
    chk("t3_full", FULL, 1);
    chk("t3_count", COUNT, 8);
    REQ_VLD = 1;
    repeat (2) tick();
    REQ_VLD = 0;
    chk("t3_ovfl", OVFL, 1);
    chk("t3_drop", DROP_CNT, 2);
    chk("t3_count_kept", COUNT, 8);
    CLR_ERR = 1; tick(); CLR_ERR = 0;
    chk("t3_clr_ovfl", OVFL, 0);
    chk("t3_clr_drop", DROP_CNT, 0);

    // Write at FULL coinciding with the final DONE pop is rejected
    wait_pres("t4_pres");
    pulse_ack();
    DONE = 1; REQ_VLD = 1; REQ_BLK1 = 4'hF;
    tick();
    DONE = 0; REQ_VLD = 0;
    chk("t4_count", COUNT, 7);
    chk("t4_drop", DROP_CNT, 1);
    chk("t4_ovfl", OVFL, 1);
    chk("t4_full", FULL, 0);
    for (int i = 1; i < 8; i++) begin
      wait_pres("t4_drain_pres");
      chk("t4_drain_radr", RADR, i);
      pulse_ack();
      pulse_done();
    end
    chk("t4_drain_count", COUNT, 0);

    // Timeout: ACK then no DONE
    send(4'd9, 4'd0, 0, 0, 8'h77, 1);
    send(4'd10, 4'd0, 0, 0, 8'h88, 0);
    wait_pres("t5_pres");
    chk("t5_radr", RADR, 9);
    pulse_ack();
    repeat (TMO) tick();
    chk("t5_pre_tmo", TMO_ERR, 0);
    chk("t5_pre_state", STATE_MON, 2);
    tick();
    chk("t5_tmo", TMO_ERR, 1);
    chk("t5_tmo_count", COUNT, 1);
    chk("t5_tmo_state", STATE_MON, 0);
    wait_pres("t5_next_pres");
    chk("t5_next_radr", RADR, 10);
    pulse_ack();
    pulse_done();
    CLR_ERR = 1; tick(); CLR_ERR = 0;
    chk("t5_clr", TMO_ERR, 0);

    // ENA dropped mid-event: event completes, then holds in IDLE
    send(4'd2, 4'd6, 1, 0, 8'h3C, 0);
    send(4'd7, 4'd0, 0, 0, 8'h5A, 1);
    wait_pres("t6_pres");
    chk("t6_radr1", RADR, 2);
    pulse_ack();
    ENA = 0;
    pulse_done();
    chk("t6_state2", STATE_MON, 3);
    chk("t6_radr2", RADR, 6);
    pulse_ack();
    pulse_done();
    repeat (3) tick();
    chk("t6_hold_state", STATE_MON, 0);
    chk("t6_hold_count", COUNT, 1);
    chk("t6_hold_empty", GTRGEMPTY, 1);
    ENA = 1;
    wait_pres("t6_next_pres");
    chk("t6_next_radr", RADR, 7);
    pulse_ack();
    pulse_done();

    // Random traffic, with one reset in the middle
    for (int c = 0; c < 4000; c++) begin
      int pct;
      pct = (c < 1500) ? 60 : ((c < 3000) ? 20 : 90);
      REQ_VLD    = ($urandom_range(0, 99) < pct);
      REQ_BLK1   = 4'($urandom);
      REQ_BLK2   = 4'($urandom);
      REQ_TWO    = 1'($urandom);
      REQ_SHARED = 1'($urandom);
      REQ_L1ABIN = 8'($urandom);
      REQ_LCTPH  = 1'($urandom);
      ACK        = ($urandom_range(0, 2) == 0);
      DONE       = ($urandom_range(0, 2) == 0);
      ENA        = ($urandom_range(0, 9) != 0);
      CLR_ERR    = ($urandom_range(0, 49) == 0);
      RST        = (c == 2000);
      tick();
    end
    RST = 0; REQ_VLD = 0; ACK = 0; DONE = 0; CLR_ERR = 0; ENA = 1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
